fp_addsub_seq: RTL
==================

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 Parameter EXP_W, default 6: exponent field width; bias = 2^(EXP_W-1)-1 (31 at default).
REQ-002 Parameter MAN_W, default 25: stored mantissa width; leading 1 is implicit; word width W = 1+EXP_W+MAN_W (32 at default).
REQ-003 clock_100kHz  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op_sub  input  1  0 = A+B, 1 = A-B; captured with the operands.
REQ-007 op_A_in, op_B_in  input  [0:W-1]  operands; index 0 = sign, [1:EXP_W] = exponent, rest = mantissa.
REQ-008 data_out  output  [0:W-1]  result, same field layout.
REQ-009 status_out  output  [0:3]  [0] exact, [1] overflow, [2] underflow, [3] inexact.
REQ-010 busy  output  1  high from the cycle after start is accepted through the cycle done is high.
REQ-011 done  output  1  one-cycle pulse when data_out/status_out are updated.

Function
REQ-012 FSM states: IDLE, UNPACK, ALIGN, ADD, NORMALIZE, ROUND, DONE; UNPACK->ALIGN->ADD->NORMALIZE->ROUND->DONE->IDLE.
REQ-013 IDLE with start=1: operands and op_sub are registered; next state UNPACK.
REQ-014 start while busy is ignored; captured operands are unaffected.
REQ-015 UNPACK: B sign inverted if op_sub; exponent 0 operand treated as zero; larger-magnitude operand ordered first.
REQ-016 ALIGN: smaller significand shifted right one bit per cycle until exponents match; shifted-out bits OR into sticky; if difference > MAN_W+2, single-cycle replacement by sticky only.
REQ-017 ADD: same effective signs add, otherwise larger minus smaller; working width MAN_W+4 (carry, hidden, guard, round; sticky separate).
REQ-018 NORMALIZE: carry-out causes one right shift with exponent +1; otherwise left shift one bit per cycle until hidden bit set, exponent -1 per shift.
REQ-019 Exact zero sum gives +0, status exact, and skips NORMALIZE.
REQ-020 ROUND: rounding per REQ-030; mantissa overflow from rounding renormalises once.
REQ-021 Overflow when result exponent >= 2^EXP_W-1 or any input exponent is all-ones: data_out = sign, exponent all-ones, mantissa 0; overflow and inexact set.
REQ-022 Underflow when result exponent would fall below 1: data_out = +0; underflow and inexact set.
REQ-023 Inexact set when any guard/round/sticky bit is nonzero; exact set if and only if no other flag is set.
REQ-024 Latency from start to done is at most 2*MAN_W+10 cycles; zero-operand inputs take the same path, with no shortcut.
REQ-025 data_out and status_out change only in the cycle done is asserted, then hold until the next done.

Reset
REQ-026 reset low: FSM to IDLE; data_out, status_out, busy, done and all internal registers to 0, independent of clock.
REQ-027 Reset mid-operation aborts the operation: no done pulse, and the pending result is discarded.
REQ-028 After reset release, the first start is accepted on the first rising edge.

Configuration
REQ-029 Macro FP_ROUND_NEAREST_EN selects the rounding mode.
REQ-030 Defined: round-to-nearest-even using guard/round/sticky. Undefined: truncation toward zero. Inexact detection is identical in both modes.

Structure
REQ-031 Package fp_pkg holds the FSM state enum, status bit index constants (ST_EXACT=0, ST_OVF=1, ST_UNF=2, ST_INX=3), and the EXP_W/MAN_W defaults.
REQ-032 Rounding logic lives in combinational sub-module fp_round, which holds the FP_ROUND_NEAREST_EN choice.

Verification (default parameters; all values hex)
REQ-033 A=3E000000 (1.0), B=3E000000, op_sub=0 -> data_out=40000000, status exact only, done exactly once.
REQ-034 A=3E000000, B=3E000000, op_sub=1 -> data_out=00000000, status exact only.
REQ-035 A=3E000000, B=02000000 (exponent difference 30), op_sub=0 -> data_out=3E000000, inexact only, in both macro settings.
REQ-036 A=B=7DFFFFFF (maximum finite), op_sub=0 -> data_out=7E000000, overflow and inexact set.
REQ-037 start pulsed again 3 cycles after acceptance with different operands -> result corresponds to the first operands only, single done.
REQ-038 reset asserted 5 cycles after start -> busy=0, done=0, data_out=0 immediately; next start completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the sequential floating-point add/subtract unit.
//   - state_t        : controller state encoding
//   - ST_*           : bit positions inside status_out[0:3]
//   - EXP_W_DEF/MAN_W_DEF : default exponent / stored-mantissa widths
package fp_pkg;

    localparam int EXP_W_DEF = 6;
    localparam int MAN_W_DEF = 25;

    localparam int ST_EXACT = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_UNF   = 2;
    localparam int ST_INX   = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UNPACK    = 3'd1,
        ALIGN     = 3'd2,
        ADD       = 3'd3,
        NORMALIZE = 3'd4,
        ROUND     = 3'd5,
        DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/fp_addsub_seq_if.sv
// fp_addsub_seq_if: request/result bundle of fp_addsub_seq.
//   start, op_sub, op_A_in, op_B_in : requester -> unit
//   data_out, status_out, busy, done: unit -> requester
// Word layout is [0:W-1]: index 0 sign, [1:EXP_W] exponent, remainder mantissa.
// status_out[0:3] = {exact, overflow, underflow, inexact}.
interface fp_addsub_seq_if
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         op_sub;
    logic [0:W-1] op_A_in;
    logic [0:W-1] op_B_in;
    logic [0:W-1] data_out;
    logic [0:3]   status_out;
    logic         busy;
    logic         done;

    modport master (
        output start, op_sub, op_A_in, op_B_in,
        input  data_out, status_out, busy, done
    );

    modport slave (
        input  start, op_sub, op_A_in, op_B_in,
        output data_out, status_out, busy, done
    );

endinterface

// File: rtl/fp_round.sv
// fp_round: combinational rounding of a normalised significand.
//   i_sig     : {hidden, mantissa[MAN_W], guard, round}
//   i_sticky  : OR of every bit below the round position
//   o_man     : rounded stored mantissa
//   o_renorm  : rounding carried into a new integer bit; exponent must be +1
//   o_inexact : any of guard/round/sticky set
// Build option: FP_ROUND_NEAREST_EN defined -> round-to-nearest-even,
// otherwise truncation toward zero. Inexact detection is the same in both.
module fp_round
    import fp_pkg::*;
#(
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic [MAN_W+2:0] i_sig,
    input  logic             i_sticky,
    output logic [MAN_W-1:0] o_man,
    output logic             o_renorm,
    output logic             o_inexact
);
    logic             w_up;
    logic [MAN_W+1:0] w_rnd;

    always_comb begin
`ifdef FP_ROUND_NEAREST_EN
        // Round up above half, or exactly half with an odd LSB.
        w_up = i_sig[1] & (i_sig[0] | i_sticky | i_sig[2]);
`else
        w_up = 1'b0;
`endif
    end

    assign w_rnd     = {1'b0, i_sig[MAN_W+2:2]} + {{(MAN_W+1){1'b0}}, w_up};
    // A carry out of 1.111..1 leaves 10.000..0, so the shifted mantissa is zero.
    assign o_renorm  = w_rnd[MAN_W+1];
    assign o_man     = o_renorm ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    assign o_inexact = i_sig[1] | i_sig[0] | i_sticky;

endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point adder/subtractor.
//   clock_100kHz : sole clock, rising edge
//   reset        : asynchronous, active low
//   bus (slave)  : start/op_sub/op_A_in/op_B_in in; data_out/status_out/busy/done out
// Build option: FP_ROUND_NEAREST_EN (consumed by fp_round) selects
// round-to-nearest-even; default build truncates toward zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; operands captured on acceptance
// UNPACK    | apply op_sub to B sign, zero detect, order by magnitude
// ALIGN     | shift smaller significand right until exponents match
// ADD       | add or subtract magnitudes, detect exact zero
// NORMALIZE | one right shift on carry, else left shift until hidden set
// ROUND     | round, range check, load data_out/status_out
// DONE      | done pulse, results visible
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic              clock_100kHz,
    input  logic              reset,
    fp_addsub_seq_if.slave    bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;          // carry, hidden, mantissa, guard, round
    localparam int EW = EXP_W + 2;          // signed working exponent

    localparam logic [EXP_W-1:0]        EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]        EXP_INC   = EXP_W'(1);
    localparam logic [EXP_W-1:0]        FAR_LIM   = EXP_W'(MAN_W + 2);
    localparam logic signed [EW-1:0]    EXP_ONE_S = EW'(1);
    localparam logic signed [EW-1:0]    EXP_MAX_S = EW'((2 ** EXP_W) - 1);

    state_t r_state, w_state_nxt;

    logic [0:W-1]            r_a, r_b;
    logic                    r_sub;
    logic                    r_big_sign, r_sml_sign;
    logic [EXP_W-1:0]        r_big_exp, r_sml_exp;
    logic [SW-1:0]           r_big_sig, r_sml_sig;
    logic                    r_sticky;
    logic                    r_inf_in;
    logic [SW-1:0]           r_sum;
    logic signed [EW-1:0]    r_exp;
    logic                    r_sign;
    logic                    r_zero;
    logic [0:W-1]            r_data;
    logic [0:3]              r_status;

    // Unpack view of the captured operands.
    logic                    w_sa, w_sb, w_za, w_zb, w_swap;
    logic [EXP_W-1:0]        w_ea, w_eb;
    logic [MAN_W-1:0]        w_ma, w_mb;
    logic [EXP_W+MAN_W-1:0]  w_mag_a, w_mag_b;
    logic [SW-1:0]           w_sig_a, w_sig_b;

    assign w_sa    = r_a[0];
    assign w_sb    = r_b[0] ^ r_sub;
    assign w_ea    = r_a[1:EXP_W];
    assign w_eb    = r_b[1:EXP_W];
    assign w_ma    = r_a[EXP_W+1:W-1];
    assign w_mb    = r_b[EXP_W+1:W-1];
    assign w_za    = (w_ea == '0);
    assign w_zb    = (w_eb == '0);
    assign w_mag_a = w_za ? '0 : {w_ea, w_ma};
    assign w_mag_b = w_zb ? '0 : {w_eb, w_mb};
    assign w_swap  = (w_mag_b > w_mag_a);
    assign w_sig_a = w_za ? '0 : {2'b01, w_ma, 2'b00};
    assign w_sig_b = w_zb ? '0 : {2'b01, w_mb, 2'b00};

    // Alignment: beyond FAR_LIM every bit would end in sticky anyway.
    logic [EXP_W-1:0] w_exp_diff;
    logic             w_far;

    assign w_exp_diff = r_big_exp - r_sml_exp;
    assign w_far      = (w_exp_diff > FAR_LIM);

    // Sticky rides along as an extra LSB so a borrow from it reaches the
    // round bit during subtraction.
    logic          w_same;
    logic [SW:0]   w_sum_ext;
    logic          w_sum_zero;

    assign w_same     = (r_big_sign == r_sml_sign);
    assign w_sum_ext  = w_same ? ({r_big_sig, 1'b0} + {r_sml_sig, r_sticky})
                               : ({r_big_sig, 1'b0} - {r_sml_sig, r_sticky});
    assign w_sum_zero = (w_sum_ext == '0);

    logic [MAN_W-1:0]     w_man;
    logic                 w_renorm, w_inexact;
    logic signed [EW-1:0] w_exp_fin;
    logic [0:W-1]         w_result;
    logic [0:3]           w_status;

    fp_round #(.MAN_W(MAN_W)) u_round (
        .i_sig     (r_sum[SW-2:0]),
        .i_sticky  (r_sticky),
        .o_man     (w_man),
        .o_renorm  (w_renorm),
        .o_inexact (w_inexact)
    );

    assign w_exp_fin = r_exp + (w_renorm ? EXP_ONE_S : '0);

    always_comb begin
        w_result = '0;
        w_status = '0;
        if (r_inf_in || (!r_zero && (w_exp_fin >= EXP_MAX_S))) begin
            w_result           = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_status[ST_OVF]   = 1'b1;
            w_status[ST_INX]   = 1'b1;
        end else if (r_zero) begin
            w_status[ST_EXACT] = 1'b1;
        end else if (w_exp_fin < EXP_ONE_S) begin
            w_status[ST_UNF]   = 1'b1;
            w_status[ST_INX]   = 1'b1;
        end else begin
            w_result           = {r_sign, w_exp_fin[EXP_W-1:0], w_man};
            w_status[ST_INX]   = w_inexact;
            w_status[ST_EXACT] = ~w_inexact;
        end
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (bus.start) w_state_nxt = UNPACK;
            UNPACK:    w_state_nxt = ALIGN;
            ALIGN:     if (r_big_exp == r_sml_exp) w_state_nxt = ADD;
            ADD:       w_state_nxt = w_sum_zero ? ROUND : NORMALIZE;
            NORMALIZE: if (r_sum[SW-1] || r_sum[SW-2]) w_state_nxt = ROUND;
            ROUND:     w_state_nxt = DONE;
            DONE:      w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            r_big_sign <= 1'b0;
            r_sml_sign <= 1'b0;
            r_big_exp  <= '0;
            r_sml_exp  <= '0;
            r_big_sig  <= '0;
            r_sml_sig  <= '0;
            r_sticky   <= 1'b0;
            r_inf_in   <= 1'b0;
            r_sum      <= '0;
            r_exp      <= '0;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_data     <= '0;
            r_status   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.op_A_in;
                        r_b   <= bus.op_B_in;
                        r_sub <= bus.op_sub;
                    end
                end
                UNPACK: begin
                    r_big_sign <= w_swap ? w_sb : w_sa;
                    r_sml_sign <= w_swap ? w_sa : w_sb;
                    r_big_exp  <= w_swap ? w_eb : w_ea;
                    r_sml_exp  <= w_swap ? w_ea : w_eb;
                    r_big_sig  <= w_swap ? w_sig_b : w_sig_a;
                    r_sml_sig  <= w_swap ? w_sig_a : w_sig_b;
                    r_sticky   <= 1'b0;
                    r_inf_in   <= (w_ea == EXP_ONES) || (w_eb == EXP_ONES);
                end
                ALIGN: begin
                    if (r_big_exp != r_sml_exp) begin
                        if (w_far) begin
                            r_sticky  <= r_sticky | (|r_sml_sig);
                            r_sml_sig <= '0;
                            r_sml_exp <= r_big_exp;
                        end else begin
                            r_sticky  <= r_sticky | r_sml_sig[0];
                            r_sml_sig <= r_sml_sig >> 1;
                            r_sml_exp <= r_sml_exp + EXP_INC;
                        end
                    end
                end
                ADD: begin
                    r_sum    <= w_sum_ext[SW:1];
                    r_sticky <= w_sum_ext[0];
                    r_zero   <= w_sum_zero;
                    r_sign   <= r_big_sign;
                    r_exp    <= $signed({2'b00, r_big_exp});
                end
                NORMALIZE: begin
                    if (r_sum[SW-1]) begin
                        r_sum    <= r_sum >> 1;
                        r_sticky <= r_sticky | r_sum[0];
                        r_exp    <= r_exp + EXP_ONE_S;
                    end else if (!r_sum[SW-2]) begin
                        r_sum <= r_sum << 1;
                        r_exp <= r_exp - EXP_ONE_S;
                    end
                end
                ROUND: begin
                    r_data   <= w_result;
                    r_status <= w_status;
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out   = r_data;
    assign bus.status_out = r_status;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == DONE);

endmodule
